// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers; DONE arrives W+2 cycles after START.
// START and HI/LO writes are ignored while BUSY. The divider is present only with `define MDU_DIV_EN.
module mult_div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  START,
  input  logic [1:0]            OP,
  input  logic [DATA_WIDTH-1:0] SRC_A,
  input  logic [DATA_WIDTH-1:0] SRC_B,
  input  logic                  HI_WE,
  input  logic                  LO_WE,
  input  logic [DATA_WIDTH-1:0] WD,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  DIV_BY_ZERO,
  output logic [DATA_WIDTH-1:0] HI,
  output logic [DATA_WIDTH-1:0] LO
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    SIGN = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   count;
  logic [W-1:0]    opnd;
  logic [2*W-1:0]  acc;
  logic            neg_res;

  logic            a_neg;
  logic            b_neg;
  logic [W-1:0]    mag_a;
  logic [W-1:0]    mag_b;
  logic            launch;
  logic [W:0]      mul_sum;
  logic [2*W-1:0]  prod_fix;

  always_comb begin
    a_neg    = OP[0] & SRC_A[W-1];
    b_neg    = OP[0] & SRC_B[W-1];
    mag_a    = a_neg ? (~SRC_A + 1'b1) : SRC_A;
    mag_b    = b_neg ? (~SRC_B + 1'b1) : SRC_B;
    // Multiplier sits in the low half of acc and is shifted out as the product fills in.
    mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : {(W+1){1'b0}});
    prod_fix = neg_res ? (~acc + 1'b1) : acc;
  end

`ifdef MDU_DIV_EN
  logic            is_div;
  logic            div_zero;
  logic            neg_rem;
  logic [W-1:0]    rem;
  logic [W:0]      shifted;
  logic [W+1:0]    diff;
  logic [W-1:0]    quo_fix;
  logic [W-1:0]    rem_fix;

  assign launch = START & (state == IDLE);

  // Dividend shifts out of acc[W-1:0] while quotient bits shift in behind it.
  always_comb begin
    shifted = {rem, acc[W-1]};
    diff    = {1'b0, shifted} - {2'b00, opnd};
    quo_fix = div_zero ? {W{1'b1}} : (neg_res ? (~acc[W-1:0] + 1'b1) : acc[W-1:0]);
    rem_fix = neg_rem ? (~rem + 1'b1) : rem;
  end
`else
  assign launch = START & (state == IDLE) & ~OP[1];
`endif

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state       <= IDLE;
      count       <= '0;
      opnd        <= '0;
      acc         <= '0;
      neg_res     <= 1'b0;
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
      DIV_BY_ZERO <= 1'b0;
      HI          <= '0;
      LO          <= '0;
`ifdef MDU_DIV_EN
      is_div      <= 1'b0;
      div_zero    <= 1'b0;
      neg_rem     <= 1'b0;
      rem         <= '0;
`endif
    end else begin
      DONE        <= 1'b0;
      DIV_BY_ZERO <= 1'b0;
      case (state)
        IDLE: begin
          if (launch) begin
            state   <= ITER;
            BUSY    <= 1'b1;
            count   <= '0;
            neg_res <= a_neg ^ b_neg;
`ifdef MDU_DIV_EN
            is_div   <= OP[1];
            neg_rem  <= a_neg;
            div_zero <= OP[1] & (SRC_B == '0);
            rem      <= '0;
            if (OP[1]) begin
              opnd <= mag_b;
              acc  <= {{W{1'b0}}, mag_a};
            end else begin
              opnd <= mag_a;
              acc  <= {{W{1'b0}}, mag_b};
            end
`else
            opnd <= mag_a;
            acc  <= {{W{1'b0}}, mag_b};
`endif
          end else begin
            if (HI_WE) HI <= WD;
            if (LO_WE) LO <= WD;
          end
        end
        ITER: begin
`ifdef MDU_DIV_EN
          if (is_div) begin
            // Restoring step: keep the subtraction only when it did not go negative.
            if (diff[W+1]) begin
              rem        <= shifted[W-1:0];
              acc[W-1:0] <= {acc[W-2:0], 1'b0};
            end else begin
              rem        <= diff[W-1:0];
              acc[W-1:0] <= {acc[W-2:0], 1'b1};
            end
          end else begin
            acc <= {mul_sum, acc[W-1:1]};
          end
`else
          acc <= {mul_sum, acc[W-1:1]};
`endif
          count <= count + 1'b1;
          if (count == CW'(W-1)) state <= SIGN;
        end
        SIGN: begin
          state <= IDLE;
          BUSY  <= 1'b0;
          DONE  <= 1'b1;
`ifdef MDU_DIV_EN
          if (is_div) begin
            HI          <= rem_fix;
            LO          <= quo_fix;
            DIV_BY_ZERO <= div_zero;
          end else begin
            {HI, LO} <= prod_fix;
          end
`else
          {HI, LO} <= prod_fix;
`endif
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule
